// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared constants and types for the 8259 PIC datapath
package pic_pkg;

  localparam int NUM_IRQ = 8;
  localparam logic [2:0] SPURIOUS_LEVEL_DEFAULT = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ACK1,
    ACK1_LOW,
    ACK2
  } state_e;

  typedef enum logic {
    EOI_NONSPECIFIC = 1'b0,
    EOI_SPECIFIC    = 1'b1
  } eoi_type_e;

endpackage

// File: rtl/isr_rotating_scan.sv
// rtl/isr_rotating_scan.sv - picks the in-service bit a rotating non-specific EOI clears
module isr_rotating_scan
  import pic_pkg::*;
(
  input  logic [NUM_IRQ-1:0] isr,
  input  logic [NUM_IRQ-1:0] last_serviced,
  output logic [NUM_IRQ-1:0] clear_bit
);

  logic [2:0] start;
  logic [2:0] idx;

  // Encode the one-hot lowest-priority marker into a level number.
  always_comb begin
    start = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (last_serviced[i]) start = 3'(i);
    end
  end

  // Walk upward from the level after the marker, wrapping; the nearest set bit wins.
  always_comb begin
    clear_bit = '0;
    idx       = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      idx = start + 3'(k) + 3'd1;
      if (isr[idx]) begin
        clear_bit      = '0;
        clear_bit[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/in_service_control.sv
// rtl/in_service_control.sv - INT/INTA sequencing, in-service register and EOI handling
module in_service_control #(
  parameter int         NUM_IRQ        = pic_pkg::NUM_IRQ,
  parameter logic [2:0] SPURIOUS_LEVEL = pic_pkg::SPURIOUS_LEVEL_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] priority_req,
  input  logic [2:0]         priority_id,
  input  logic               inta,
  input  logic [4:0]         vector_base,
  input  logic               aeoi,
  input  logic               rotate_mode,
  input  logic               eoi_cmd,
  input  logic               eoi_specific,
  input  logic [2:0]         eoi_level,
  output logic               int_out,
  output logic [NUM_IRQ-1:0] isr,
  output logic [NUM_IRQ-1:0] last_serviced,
  output logic [NUM_IRQ-1:0] clear_irr,
  output logic [7:0]         vector_out,
  output logic               vector_valid
);
  import pic_pkg::*;

  state_e             state, state_n;
  logic               inta_q, rise_p, fall_p;
  logic [2:0]         id_q;
  logic               spurious_q;
  logic               ack_take, load_vector, ack_done;
  logic [NUM_IRQ-1:0] set_vec, aeoi_clear, eoi_clear, scan_bit;

  isr_rotating_scan u_scan (
    .isr          (isr),
    .last_serviced(last_serviced),
    .clear_bit    (scan_bit)
  );

  // Edge pulses on inta, registered so the FSM acts one cycle after detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      inta_q <= 1'b0;
      rise_p <= 1'b0;
      fall_p <= 1'b0;
    end else begin
      inta_q <= inta;
      rise_p <= inta & ~inta_q;
      fall_p <= ~inta & inta_q;
    end
  end

  // Acknowledge sequencing plus the set/clear requests each state produces.
  always_comb begin
    state_n     = state;
    ack_take    = 1'b0;
    load_vector = 1'b0;
    ack_done    = 1'b0;
    case (state)
      IDLE:     if (priority_req != '0 && !inta) state_n = REQ;
      REQ:      if (rise_p) begin
                  state_n  = ACK1;
                  ack_take = 1'b1;
                end
      ACK1:     if (fall_p) state_n = ACK1_LOW;
      ACK1_LOW: if (rise_p) begin
                  state_n     = ACK2;
                  load_vector = 1'b1;
                end
      ACK2:     if (fall_p) begin
                  state_n  = IDLE;
                  ack_done = 1'b1;
                end
      default:  state_n = IDLE;
    endcase
    set_vec    = (ack_take && priority_req != '0) ? (NUM_IRQ'(1) << priority_id) : '0;
    aeoi_clear = (ack_done && aeoi && !spurious_q) ? (NUM_IRQ'(1) << id_q) : '0;
  end

  // EOI selection always looks at the current ISR, before any set this cycle.
  always_comb begin
    eoi_clear = '0;
    if (eoi_cmd) begin
      if (eoi_type_e'(eoi_specific) == EOI_SPECIFIC)
        eoi_clear = isr & (NUM_IRQ'(1) << eoi_level);
      else if (rotate_mode)
        eoi_clear = scan_bit;
      else
        eoi_clear = isr & (~isr + NUM_IRQ'(1));
    end
  end

  assign int_out      = (state == REQ);
  assign vector_valid = (state == ACK2);

  // State, ISR, rotation marker, IRR clear pulse and vector byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      isr           <= '0;
      last_serviced <= NUM_IRQ'(1) << (NUM_IRQ - 1);
      clear_irr     <= '0;
      vector_out    <= '0;
      id_q          <= '0;
      spurious_q    <= 1'b0;
    end else begin
      state     <= state_n;
      isr       <= (isr & ~eoi_clear & ~aeoi_clear) | set_vec;
      clear_irr <= set_vec != '0 ? priority_req : '0;
      if (rotate_mode && eoi_clear != '0)
        last_serviced <= eoi_clear;
      else if (rotate_mode && aeoi_clear != '0)
        last_serviced <= aeoi_clear;
      if (ack_take) begin
        id_q       <= (priority_req != '0) ? priority_id : SPURIOUS_LEVEL;
        spurious_q <= (priority_req == '0);
      end
      if (load_vector) vector_out <= {vector_base, id_q};
    end
  end

endmodule

// File: tb/tb_in_service_control.sv
// tb/tb_in_service_control.sv - scoreboard bench for in_service_control
module tb_in_service_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] priority_req;
  logic [2:0] priority_id;
  logic       inta;
  logic [4:0] vector_base;
  logic       aeoi, rotate_mode, eoi_cmd, eoi_specific;
  logic [2:0] eoi_level;
  logic       int_out;
  logic [7:0] isr, last_serviced, clear_irr, vector_out;
  logic       vector_valid;

  always #5 clk = ~clk;

  in_service_control dut (
    .clk(clk), .rst(rst), .priority_req(priority_req), .priority_id(priority_id),
    .inta(inta), .vector_base(vector_base), .aeoi(aeoi), .rotate_mode(rotate_mode),
    .eoi_cmd(eoi_cmd), .eoi_specific(eoi_specific), .eoi_level(eoi_level),
    .int_out(int_out), .isr(isr), .last_serviced(last_serviced), .clear_irr(clear_irr),
    .vector_out(vector_out), .vector_valid(vector_valid)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0] vec_q[$];
  logic [7:0] clr_q[$];
  logic [7:0] m_isr;
  int         m_ls;
  logic       vv_prev = 1'b0;
  logic [7:0] clr_prev = 8'h00;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] onehot(int l);
    logic [7:0] one = 8'd1;
    return one << l;
  endfunction

  // Reference EOI: find the level to clear from the ISR contents, then apply it.
  function automatic void m_eoi(bit spec, int lvl, bit rot);
    int hit = -1;
    if (spec) begin
      if (m_isr[lvl]) hit = lvl;
    end else if (!rot) begin
      for (int i = 0; i < 8; i++) if (hit < 0 && m_isr[i]) hit = i;
    end else begin
      for (int k = 1; k <= 8; k++) if (hit < 0 && m_isr[(m_ls + k) % 8]) hit = (m_ls + k) % 8;
    end
    if (hit >= 0) begin
      m_isr[hit] = 1'b0;
      if (rot) m_ls = hit;
    end
  endfunction

  // Monitor: pop expected vectors / IRR clears whenever the DUT presents them.
  always @(negedge clk) begin
    if (rst) begin
      vv_prev  = 1'b0;
      clr_prev = 8'h00;
    end else begin
      if (vector_valid && !vv_prev) begin
        if (vec_q.size() == 0) check("unexpected_vector", {24'd0, vector_out}, 32'hffff_ffff);
        else check("vector_out", {24'd0, vector_out}, {24'd0, vec_q.pop_front()});
      end
      if (clear_irr != 8'h00) begin
        if (clr_prev != 8'h00) check("clear_irr_width", {24'd0, clr_prev}, 32'd0);
        else if (clr_q.size() == 0) check("unexpected_clear_irr", {24'd0, clear_irr}, 32'd0);
        else check("clear_irr", {24'd0, clear_irr}, {24'd0, clr_q.pop_front()});
      end
      vv_prev  = vector_valid;
      clr_prev = clear_irr;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_eoi(bit spec, int lvl, bit rot);
    rotate_mode  = rot;
    eoi_cmd      = 1'b1;
    eoi_specific = spec;
    eoi_level    = 3'(lvl);
    tick(1);
    eoi_cmd = 1'b0;
    m_eoi(spec, lvl, rot);
    tick(1);
    check("eoi_isr", {24'd0, isr}, {24'd0, m_isr});
    check("eoi_last_serviced", {24'd0, last_serviced}, {24'd0, onehot(m_ls)});
  endtask

  task automatic do_ack(int lvl, bit sp, bit ae, bit rot, logic [4:0] vb, bit collide, bit rst_mid);
    int n = 0;
    priority_req = onehot(lvl);
    priority_id  = 3'(lvl);
    aeoi         = ae;
    rotate_mode  = rot;
    vector_base  = vb;
    while (!int_out && n < 10) begin
      tick(1);
      n++;
    end
    check("int_out_rise", {31'd0, int_out}, 32'd1);
    if (sp) begin
      priority_req = 8'h00;
      tick(2);
      check("int_out_held_spurious", {31'd0, int_out}, 32'd1);
    end else begin
      clr_q.push_back(onehot(lvl));
    end
    vec_q.push_back({vb, sp ? 3'd7 : 3'(lvl)});
    inta = 1'b1;
    tick(1);
    if (collide) begin
      eoi_cmd      = 1'b1;
      eoi_specific = 1'b1;
      eoi_level    = 3'(lvl);
      m_eoi(1'b1, lvl, rot);
      tick(1);
      eoi_cmd = 1'b0;
      tick(2);
    end else begin
      tick(3);
    end
    if (!sp) m_isr[lvl] = 1'b1;
    inta         = 1'b0;
    priority_req = 8'h00;
    tick(4);
    check("isr_after_first_inta", {24'd0, isr}, {24'd0, m_isr});
    check("int_out_low_in_ack", {31'd0, int_out}, 32'd0);
    inta = 1'b1;
    tick(4);
    check("vector_valid_held", {31'd0, vector_valid}, 32'd1);
    if (rst_mid) begin
      rst  = 1'b1;
      inta = 1'b0;
      tick(1);
      rst   = 1'b0;
      m_isr = 8'h00;
      m_ls  = 7;
      check("rst_vector_valid", {31'd0, vector_valid}, 32'd0);
      check("rst_isr", {24'd0, isr}, 32'd0);
      check("rst_int_out", {31'd0, int_out}, 32'd0);
      check("rst_last_serviced", {24'd0, last_serviced}, 32'h80);
      check("rst_vector_out", {24'd0, vector_out}, 32'd0);
      tick(2);
      return;
    end
    inta = 1'b0;
    tick(4);
    if (ae && !sp) begin
      m_isr[lvl] = 1'b0;
      if (rot) m_ls = lvl;
    end
    check("isr_after_ack", {24'd0, isr}, {24'd0, m_isr});
    check("last_serviced_after_ack", {24'd0, last_serviced}, {24'd0, onehot(m_ls)});
    check("vector_valid_dropped", {31'd0, vector_valid}, 32'd0);
    check("int_out_idle", {31'd0, int_out}, 32'd0);
  endtask

  initial begin
    int  lvl, elvl;
    bit  sp, ae, rot, espec;
    logic [4:0] vb;
    rst = 1'b1; priority_req = 8'h00; priority_id = 3'd0; inta = 1'b0;
    vector_base = 5'd0; aeoi = 1'b0; rotate_mode = 1'b0; eoi_cmd = 1'b0;
    eoi_specific = 1'b0; eoi_level = 3'd0;
    m_isr = 8'h00; m_ls = 7;
    tick(3);
    check("reset_int_out", {31'd0, int_out}, 32'd0);
    check("reset_isr", {24'd0, isr}, 32'd0);
    check("reset_last_serviced", {24'd0, last_serviced}, 32'h80);
    check("reset_clear_irr", {24'd0, clear_irr}, 32'd0);
    check("reset_vector_out", {24'd0, vector_out}, 32'd0);
    check("reset_vector_valid", {31'd0, vector_valid}, 32'd0);
    rst = 1'b0;
    tick(2);

    do_ack(2, 1'b0, 1'b0, 1'b0, 5'h08, 1'b0, 1'b0);
    do_ack(2, 1'b0, 1'b1, 1'b1, 5'h08, 1'b0, 1'b0);
    do_ack(4, 1'b1, 1'b0, 1'b0, 5'h11, 1'b0, 1'b0);
    do_ack(3, 1'b0, 1'b0, 1'b0, 5'h02, 1'b0, 1'b0);
    do_ack(5, 1'b0, 1'b0, 1'b0, 5'h02, 1'b0, 1'b0);
    check("isr_28", {24'd0, isr}, 32'h28);
    do_eoi(1'b0, 0, 1'b0);
    do_eoi(1'b0, 0, 1'b1);
    do_eoi(1'b0, 0, 1'b0);
    do_eoi(1'b1, 6, 1'b1);
    do_ack(3, 1'b0, 1'b0, 1'b0, 5'h1f, 1'b1, 1'b0);
    check("collision_isr3", {31'd0, isr[3]}, 32'd1);

    for (int t = 0; t < 40; t++) begin
      lvl   = int'($urandom_range(0, 7));
      sp    = ($urandom_range(0, 3) == 0);
      ae    = 1'($urandom_range(0, 1));
      rot   = 1'($urandom_range(0, 1));
      vb    = 5'($urandom);
      do_ack(lvl, sp, ae, rot, vb, ($urandom_range(0, 5) == 0), 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        espec = 1'($urandom_range(0, 1));
        elvl  = int'($urandom_range(0, 7));
        do_eoi(espec, elvl, 1'($urandom_range(0, 1)));
      end
    end

    do_ack(6, 1'b0, 1'b0, 1'b1, 5'h0a, 1'b0, 1'b1);
    tick(5);
    check("vector_queue_drained", vec_q.size(), 32'd0);
    check("clear_queue_drained", clr_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/in_service_control.md
Name: in_service_control

Overview:
- Downstream stage of the priority resolver in the 8259 PIC. Consumes the resolver's one-hot winner and its 3-bit ID.
- Drives INT to the CPU, runs the two-pulse INTA acknowledge sequence, and owns the In-Service Register (ISR).
- Produces the interrupt vector byte and processes EOI commands.
- Feeds `isr` and `last_serviced` back to the resolver for nesting and rotation.

Parameters:
- NUM_IRQ, 8, number of request lines; only 8 is supported.
- SPURIOUS_LEVEL, 7, level reported when the request vanishes before the first INTA.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- priority_req  input  8  one-hot winner from the priority resolver; 0 = none
- priority_id  input  3  encoded winner from the priority resolver
- inta  input  1  already-synchronised interrupt acknowledge, active-high level
- vector_base  input  5  ICW2 bits T7..T3
- aeoi  input  1  automatic-EOI mode (ICW4)
- rotate_mode  input  1  rotating-priority mode (OCW2 state)
- eoi_cmd  input  1  one-cycle EOI command strobe
- eoi_specific  input  1  with eoi_cmd: 1 = specific EOI, 0 = non-specific
- eoi_level  input  3  level cleared by a specific EOI
- int_out  output  1  interrupt request to the CPU
- isr  output  8  In-Service Register
- last_serviced  output  8  one-hot lowest-priority marker for rotation
- clear_irr  output  8  one-cycle one-hot pulse clearing the IRR edge latch
- vector_out  output  8  vector byte
- vector_valid  output  1  vector_out is valid and must be driven to the data bus

Behaviour:
- Reset values: int_out=0, isr=0, last_serviced=8'h80, clear_irr=0, vector_out=0, vector_valid=0, state IDLE.
- `inta` rise and fall are detected against a registered copy of `inta`; edges act one cycle after detection.
- FSM IDLE:
  - priority_req!=0 and inta=0 -> REQ; int_out=1 from the next cycle.
- FSM REQ:
  - int_out held at 1.
  - Rising inta edge with priority_req!=0 -> set isr[priority_id], pulse clear_irr=priority_req for one cycle, latch id_q=priority_id, go to ACK1.
  - Rising inta edge with priority_req==0 (spurious) -> isr and clear_irr unchanged, id_q=SPURIOUS_LEVEL, go to ACK1.
  - priority_req==0 with no inta edge -> int_out stays 1 (CPU will see a spurious acknowledge).
- FSM ACK1:
  - int_out=0.
  - Falling inta edge -> ACK1_LOW.
- FSM ACK1_LOW:
  - Rising inta edge -> ACK2; vector_out={vector_base,id_q} and vector_valid=1 from the next cycle.
- FSM ACK2:
  - vector_valid stays 1 while inta=1.
  - Falling inta edge -> vector_valid=0, go to IDLE.
  - If aeoi=1 and the acknowledge was not spurious, clear isr[id_q] on that same falling edge. When rotate_mode=1, also set last_serviced=1<<id_q.
- INT re-assertion: after returning to IDLE, int_out may rise again no earlier than the following cycle.
- Non-specific EOI (eoi_cmd=1, eoi_specific=0):
  - rotate_mode=0: clear the lowest-numbered set ISR bit.
  - rotate_mode=1: clear the first set bit scanning upward, wrapping, from the position after last_serviced's set bit.
  - ISR==0: no effect.
- Specific EOI: clear isr[eoi_level]; no effect if that bit is already 0.
- Rotation on EOI: when rotate_mode=1 and an EOI clears a bit at level L, last_serviced=1<<L in the same cycle.
- EOI is accepted in every FSM state.
- Simultaneous set and clear in one cycle: the clear is computed on the old ISR, then the set is ORed in, so set wins on the same bit.
- rst asserted mid-sequence: everything returns to reset values on the next edge; a pending vector is abandoned.
- clear_irr is never high for more than one cycle per acknowledge.

Decomposition:
- Shared package pic_pkg:
  - NUM_IRQ
  - FSM state enum IDLE/REQ/ACK1/ACK1_LOW/ACK2
  - EOI type constants
  - SPURIOUS_LEVEL default
- One sub-module, isr_rotating_scan (combinational): inputs isr and last_serviced, outputs the one-hot bit to clear. Reused later by the resolver cleanup.

Test Plan:
- Basic acknowledge: priority_req=8'h04, id=2, vector_base=5'h08, two INTA pulses -> int_out rises; isr=8'h04 after the first pulse; clear_irr=8'h04 for exactly one cycle; vector_out=8'h42 with vector_valid=1 during the second pulse; isr stays 8'h04.
- AEOI: same stimulus with aeoi=1 -> isr returns to 0 on the second INTA fall. With rotate_mode=1, last_serviced=8'h04.
- Spurious: priority_req drops to 0 before the first INTA -> isr unchanged, no clear_irr pulse, vector_out={vector_base,3'd7}.
- Non-specific EOI: isr=8'h28, rotate_mode=0 -> isr=8'h20. Then with rotate_mode=1 and last_serviced=8'h20 -> next EOI clears bit 5 and gives last_serviced=8'h20.
- Collision: eoi_cmd specific level 3 in the same cycle the first INTA sets isr[3] -> isr[3]=1 afterwards.
- Reset mid-ACK2: assert rst during the second pulse -> vector_valid=0, isr=0, int_out=0, last_serviced=8'h80 next cycle.
